// File: rtl/pipeline_addsub_pkg.sv
// rtl/pipeline_addsub_pkg.sv - shared op encodings and slice geometry for the sliced add/sub pipeline
package pipeline_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    int width;
    int offset;
  } slice_t;

  // Slices are equal width, LSB first; the top slice absorbs the remainder bits.
  function automatic slice_t slice_info(int dwidth, int num_stages, int idx);
    slice_t si;
    int base;
    base      = dwidth / num_stages;
    si.offset = idx * base;
    si.width  = (idx == num_stages - 1) ? base + (dwidth % num_stages) : base;
    return si;
  endfunction

endpackage

// File: rtl/pipeline_addsub_if.sv
// rtl/pipeline_addsub_if.sv - operand/result handshake bundle for pipeline_addsub
interface pipeline_addsub_if #(
  parameter int DWIDTH = 8
);

  logic [DWIDTH-1:0] in1;
  logic [DWIDTH-1:0] in2;
  logic              cin;
  logic              op;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] sum;
  logic              carry;
  logic              overflow;
  logic              zero;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output in1, in2, cin, op, in_valid, out_ready,
    input  in_ready, sum, carry, overflow, zero, out_valid, busy
  );

  modport slave (
    input  in1, in2, cin, op, in_valid, out_ready,
    output in_ready, sum, carry, overflow, zero, out_valid, busy
  );

endinterface

// File: rtl/pipeline_addsub_slice.sv
// rtl/pipeline_addsub_slice.sv - combinational add/sub slice with carry-out and carry into its MSB
module addsub_slice #(
  parameter int SWIDTH = 4
) (
  input  logic [SWIDTH-1:0] a,
  input  logic [SWIDTH-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [SWIDTH-1:0] s,
  output logic              cout,
  output logic              c_msb
);

  logic [SWIDTH-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, s}   = {1'b0, a} + {1'b0, b_eff} + {{SWIDTH{1'b0}}, cin};
  // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it.
  assign c_msb       = s[SWIDTH-1] ^ a[SWIDTH-1] ^ b_eff[SWIDTH-1];

endmodule

// File: rtl/pipeline_addsub.sv
// rtl/pipeline_addsub.sv - carry-pipelined adder/subtractor, one slice per stage, global stall
module pipeline_addsub
  import pipeline_addsub_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  pipeline_addsub_if.slave bus
);

  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] op_q;
  logic [NUM_STAGES-1:0] c_q;
  logic [DWIDTH-1:0]     a_q   [NUM_STAGES];
  logic [DWIDTH-1:0]     b_q   [NUM_STAGES];
  logic [DWIDTH-1:0]     res_q [NUM_STAGES];
  logic                  ovf_q;
  logic                  zero_q;

  logic [NUM_STAGES-1:0] v_d;
  logic [NUM_STAGES-1:0] op_d;
  logic [NUM_STAGES-1:0] c_d;
  logic [NUM_STAGES-1:0] ovf_d;
  logic [DWIDTH-1:0]     a_d   [NUM_STAGES];
  logic [DWIDTH-1:0]     b_d   [NUM_STAGES];
  logic [DWIDTH-1:0]     res_d [NUM_STAGES];
  logic                  zero_d;
  logic                  advance;

  // Any stall freezes every stage so in-flight operand skew stays aligned.
  assign advance = !v_q[NUM_STAGES-1] || bus.out_ready;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam slice_t SI  = slice_info(DWIDTH, NUM_STAGES, k);
    localparam int     OFF = SI.offset;
    localparam int     W   = SI.width;

    logic [W-1:0]      a_sl;
    logic [W-1:0]      b_sl;
    logic [W-1:0]      s_sl;
    logic              cin_sl;
    logic              sub_sl;
    logic              cout_sl;
    logic              cmsb_sl;
    logic              v_src;
    logic [DWIDTH-1:0] a_src;
    logic [DWIDTH-1:0] b_src;
    logic [DWIDTH-1:0] res_prev;
    logic              unused_skew;

    if (k == 0) begin : g_first
      assign a_src    = bus.in1;
      assign b_src    = bus.in2;
      assign v_src    = bus.in_valid;
      assign sub_sl   = bus.op;
      assign cin_sl   = (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
      assign res_prev = '0;
    end else begin : g_next
      assign a_src    = a_q[k-1];
      assign b_src    = b_q[k-1];
      assign v_src    = v_q[k-1];
      assign sub_sl   = op_q[k-1];
      assign cin_sl   = c_q[k-1];
      assign res_prev = res_q[k-1];
    end

    assign a_sl = a_src[OFF +: W];
    assign b_sl = b_src[OFF +: W];

    addsub_slice #(
      .SWIDTH (W)
    ) u_slice (
      .a     (a_sl),
      .b     (b_sl),
      .cin   (cin_sl),
      .sub   (sub_sl),
      .s     (s_sl),
      .cout  (cout_sl),
      .c_msb (cmsb_sl)
    );

    assign v_d[k]   = v_src;
    assign op_d[k]  = sub_sl;
    assign c_d[k]   = cout_sl;
    assign ovf_d[k] = cmsb_sl ^ cout_sl;
    assign a_d[k]   = a_src;
    assign b_d[k]   = b_src;
    assign res_d[k] = res_prev | (DWIDTH'(s_sl) << OFF);

    // Already-consumed operand bits and the last stage's skew copy have no reader.
    assign unused_skew = ^{a_q[k], b_q[k], op_q[k], ovf_d[k]};
  end

  assign zero_d = (res_d[NUM_STAGES-1] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      op_q   <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (advance) begin
      v_q    <= v_d;
      op_q   <= op_d;
      c_q    <= c_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d[NUM_STAGES-1];
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[NUM_STAGES-1];
  assign bus.sum       = res_q[NUM_STAGES-1];
  assign bus.carry     = c_q[NUM_STAGES-1];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = |v_q;

endmodule

// File: tb/tb_pipeline_addsub.sv
// tb/tb_pipeline_addsub.sv - scoreboard bench for pipeline_addsub in 8/2 and 10/3 configurations
module tb_pipeline_addsub;
  import pipeline_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_addsub_if #(.DWIDTH(8))  ia ();
  pipeline_addsub_if #(.DWIDTH(10)) ib ();

  pipeline_addsub #(.DWIDTH(8),  .NUM_STAGES(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  pipeline_addsub #(.DWIDTH(10), .NUM_STAGES(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int errors = 0;
  int checks = 0;
  int a_outs = 0;
  int b_outs = 0;
  bit rand_ready = 1'b0;
  logic [66:0] qa[$];
  logic [66:0] qb[$];
  logic [66:0] snap;
  int base_outs;

  task automatic check(string tag, logic [66:0] got, logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as {sum, carry, overflow, zero}; overflow from operand/result signs.
  function automatic logic [66:0] model(int dw, logic [63:0] a, logic [63:0] b, logic cin, logic op);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] bb;
    logic [63:0] s;
    logic        c0;
    logic        ovf;
    mask = (64'd1 << dw) - 64'd1;
    bb   = op ? (~b & mask) : b;
    c0   = op ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bb} + {64'd0, c0};
    s    = full[63:0] & mask;
    ovf  = (a[dw-1] == bb[dw-1]) && (s[dw-1] != a[dw-1]);
    return {s, full[dw], ovf, (s == 64'd0)};
  endfunction

  always @(negedge clk) begin
    #2;
    if (!rst && ia.out_valid && ia.out_ready) begin
      a_outs++;
      check("a_pending", 67'(qa.size() != 0), 67'd1);
      if (qa.size() != 0) check("a_res", {64'(ia.sum), ia.carry, ia.overflow, ia.zero}, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && ib.out_valid && ib.out_ready) begin
      b_outs++;
      check("b_pending", 67'(qb.size() != 0), 67'd1);
      if (qb.size() != 0) check("b_res", {64'(ib.sum), ib.carry, ib.overflow, ib.zero}, qb.pop_front());
    end
  end

  always @(negedge clk) if (rand_ready) ib.out_ready = ($urandom_range(0, 3) != 0);

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(bit to_b, logic [63:0] a, logic [63:0] b, logic cin, logic op);
    int   t = 0;
    logic rdy;
    if (to_b) begin
      ib.in1 = a[9:0]; ib.in2 = b[9:0]; ib.cin = cin; ib.op = op; ib.in_valid = 1'b1;
    end else begin
      ia.in1 = a[7:0]; ia.in2 = b[7:0]; ia.cin = cin; ia.op = op; ia.in_valid = 1'b1;
    end
    #2;
    rdy = to_b ? ib.in_ready : ia.in_ready;
    while (!rdy && t < 100) begin
      @(negedge clk); #2;
      rdy = to_b ? ib.in_ready : ia.in_ready;
      t++;
    end
    check(to_b ? "b_accept" : "a_accept", 67'(rdy), 67'd1);
    if (to_b) qb.push_back(model(10, 64'(a[9:0]), 64'(b[9:0]), cin, op));
    else      qa.push_back(model(8, 64'(a[7:0]), 64'(b[7:0]), cin, op));
    @(negedge clk);
    if (to_b) ib.in_valid = 1'b0; else ia.in_valid = 1'b0;
  endtask

  task automatic check_latency(string tag, bit to_b, int exp);
    int lat = 1;
    #1;
    while (!(to_b ? ib.out_valid : ia.out_valid) && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    check(tag, 67'(lat), 67'(exp));
  endtask

  task automatic wait_drain(string tag, bit to_b);
    int t = 0;
    while ((to_b ? qb.size() : qa.size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, 67'(to_b ? qb.size() : qa.size()), 67'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ia.in1 = '0; ia.in2 = '0; ia.cin = 1'b0; ia.op = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    ib.in1 = '0; ib.in2 = '0; ib.cin = 1'b0; ib.op = 1'b0; ib.in_valid = 1'b0; ib.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_a_data", {64'(ia.sum), ia.carry, ia.overflow, ia.zero}, 67'd0);
    check("rst_a_ctl",  67'({ia.out_valid, ia.busy, ia.in_ready}), 67'b001);
    check("rst_b_data", {64'(ib.sum), ib.carry, ib.overflow, ib.zero}, 67'd0);
    check("rst_b_ctl",  67'({ib.out_valid, ib.busy, ib.in_ready}), 67'b001);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(0, 64'hFF, 64'h01, 1'b0, OP_ADD);
    check_latency("a_latency", 0, 2);
    wait_drain("a_drain_first", 0);

    send(0, 64'h05, 64'h07, 1'b0, OP_SUB);
    send(0, 64'h7F, 64'h01, 1'b0, OP_ADD);
    send(0, 64'h80, 64'h01, 1'b0, OP_SUB);
    send(0, 64'h00, 64'h00, 1'b1, OP_SUB);
    send(0, 64'hFF, 64'hFF, 1'b1, OP_ADD);
    send(0, 64'h80, 64'h80, 1'b0, OP_ADD);
    send(0, 64'h33, 64'h33, 1'b1, OP_SUB);
    wait_drain("a_drain_directed", 0);

    base_outs = a_outs;
    for (int i = 0; i < 8; i++)
      send(0, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'(i % 2));
    #3;
    check("a_throughput", 67'(a_outs - base_outs), 67'd7);
    wait_drain("a_drain_alt", 0);

    ia.out_ready = 1'b0;
    send(0, 64'h12, 64'h34, 1'b0, OP_ADD);
    send(0, 64'h90, 64'hA0, 1'b1, OP_SUB);
    ia.in1 = 8'h55; ia.in2 = 8'h66; ia.cin = 1'b0; ia.op = OP_ADD; ia.in_valid = 1'b1;
    #2;
    snap = {64'(ia.sum), ia.carry, ia.overflow, ia.zero};
    for (int i = 0; i < 5; i++) begin
      check("stall_ctl",  67'({ia.in_ready, ia.out_valid, ia.busy}), 67'b011);
      check("stall_hold", {64'(ia.sum), ia.carry, ia.overflow, ia.zero}, snap);
      @(negedge clk); #2;
    end
    @(negedge clk);
    ia.out_ready = 1'b1;
    send(0, 64'h55, 64'h66, 1'b0, OP_ADD);
    wait_drain("a_drain_stall", 0);

    send(1, 64'h3FF, 64'h001, 1'b0, OP_ADD);
    check_latency("b_latency", 1, 3);
    wait_drain("b_drain_first", 1);
    send(1, 64'h000, 64'h001, 1'b0, OP_SUB);
    send(1, 64'h1FF, 64'h001, 1'b0, OP_ADD);
    send(1, 64'h200, 64'h001, 1'b0, OP_SUB);
    send(1, 64'h155, 64'h2AA, 1'b1, OP_ADD);
    wait_drain("b_drain_directed", 1);

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send(1, 64'($urandom_range(0, 1023)), 64'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(negedge clk);
    ib.out_ready = 1'b1;
    wait_drain("b_drain_random", 1);

    send(0, 64'h21, 64'h43, 1'b0, OP_ADD);
    send(0, 64'h99, 64'h11, 1'b1, OP_SUB);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_ctl",  67'({ia.out_valid, ia.busy, ia.in_ready}), 67'b001);
    check("mid_rst_data", {64'(ia.sum), ia.carry, ia.overflow, ia.zero}, 67'd0);
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 64'hC8, 64'h64, 1'b1, OP_SUB);
    check_latency("a_latency_post_rst", 0, 2);
    wait_drain("a_drain_post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
